// File: rtl/div_iter.sv
// Iterative 32-bit divider (signed/unsigned), restoring shift-subtract, one bit per clock.
// Define DIV_EARLY_EXIT_EN to finish at once when |dividend| < |divisor|.
//
// state     | meaning
// S_IDLE    | waiting for start_i; outputs cleared
// S_DIVZERO | divisor was zero; result forced to 0 on the next edge
// S_ON      | 32 shift-subtract steps, cnt 0..31
// S_END     | result valid, held until start_i drops
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dsr_q;
  logic        neg_quo_q;
  logic        neg_rem_q;

  logic [31:0] dvd_abs;
  logic [31:0] dsr_abs;
  logic        early_exit;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] quo_nxt;
  logic [31:0] rem_nxt;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    dvd_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    dsr_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
`ifdef DIV_EARLY_EXIT_EN
    early_exit = (opdata2_i != 32'd0) && (dvd_abs < dsr_abs);
`else
    early_exit = 1'b0;
`endif
  end

  // Partial remainder never exceeds the divisor, so a 33-bit trial subtract
  // decides each quotient bit from its sign.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dsr_q};
    rem_nxt = trial[32] ? shifted[31:0] : trial[31:0];
    quo_nxt = {quo_q[30:0], ~trial[32]};
    quo_fix = neg_quo_q ? (~quo_nxt + 32'd1) : quo_nxt;
    rem_fix = neg_rem_q ? (~rem_nxt + 32'd1) : rem_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ready_o   <= 1'b0;
      result_o  <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            dsr_q     <= dsr_abs;
            quo_q     <= dvd_abs;
            rem_q     <= '0;
            cnt       <= '0;
            neg_quo_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_q <= signed_div_i && opdata1_i[31];
            if (opdata2_i == 32'd0) begin
              state <= S_DIVZERO;
            end else if (early_exit) begin
              state    <= S_END;
              ready_o  <= 1'b1;
              result_o <= {opdata1_i, 32'd0};
            end else begin
              state <= S_ON;
            end
          end
        end
        S_DIVZERO: begin
          if (annul_i) begin
            state <= S_IDLE;
          end else begin
            state    <= S_END;
            ready_o  <= 1'b1;
            result_o <= '0;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state    <= S_END;
              ready_o  <= 1'b1;
              result_o <= {rem_fix, quo_fix};
            end
          end
        end
        S_END: begin
          if (!start_i) begin
            state    <= S_IDLE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
